// File: rtl/dcache_s2_pkg.sv
// Shared definitions for the data cache compare/refill stage: widths, FSM encoding
// (common with dcache_s1), load size codes and the store byte-merge helper.
package dcache_s2_pkg;

    localparam int TAG_W  = 21;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CA_READ = 2'd1,
        UC_READ = 2'd2,
        WRITE   = 2'd3
    } s2_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_load_align.sv
// Right-aligns and zero-extends a byte, halfword or word out of a 32-bit bus word.
module dcache_load_align
    import dcache_s2_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    output logic [31:0] data
);

    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;

    assign byte_shifted = word >> {offset, 3'b000};
    assign half_shifted = word >> {offset[1], 4'b0000};

    always_comb begin
        data = word;
        case (size)
            SIZE_BYTE: data = {24'b0, byte_shifted[7:0]};
            SIZE_HALF: data = {16'b0, half_shifted[15:0]};
            default:   data = word;
        endcase
    end

endmodule

// File: rtl/dcache_s2.sv
// Data cache stage 2: 2-way hit check, load return, store-hit merge for s1, and
// sequencing of AXI line refills, uncached loads and write-through stores.
module dcache_s2
    import dcache_s2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       s2_virtual_addr_i,
    input  logic [31:0]       s2_physical_addr_i,
    input  logic [TAG_W-1:0]  s2_tagv_w0_i,
    input  logic [TAG_W-1:0]  s2_tagv_w1_i,
    input  logic              s2_valid0_i,
    input  logic              s2_valid1_i,
    input  logic [31:0]       s2_data_way0_i,
    input  logic [31:0]       s2_data_way1_i,
    input  logic              s2_cache_rreq_i,
    input  logic              s2_cache_wreq_i,
    input  logic              s2_uc_rreq_i,
    input  logic              s2_uc_wreq_i,
    input  logic [3:0]        s2_bus_wen_i,
    input  logic [31:0]       s2_bus_wdata_i,
    input  logic [1:0]        s2_bus_load_size_i,
    output logic              s2_hit1_o,
    output logic              s2_hit2_o,
    output logic              s2_s2rreq_o,
    output logic              s2_s2wreq_o,
    output logic [1:0]        s2_status_o,
    output logic              s2_hit_wen_o,
    output logic [LINE_W-1:0] s2_hit_rdata_o,
    output logic              s2_stall_o,
    output logic [31:0]       s2_rdata_o,
    output logic              axi_rreq_o,
    output logic [31:0]       axi_raddr_o,
    output logic              axi_rlen_o,
    input  logic              axi_rend_i,
    input  logic [LINE_W-1:0] axi_rline_i,
    output logic              axi_wreq_o,
    output logic [31:0]       axi_waddr_o,
    output logic [31:0]       axi_wdata_o,
    output logic [3:0]        axi_wstrb_o,
    input  logic              axi_wend_i
);

    s2_state_e   state_q, state_d;
    logic        done_q;
    logic [31:0] rdata_q;
    logic        hit0, hit1, hit_any;
    logic        accept, need_bus, load_hit;
    logic [2:0]  bank;
    logic [31:0] hit_word, merged_word, align_in, aligned;
    logic        unused_vaddr;

    assign hit0     = s2_valid0_i & (s2_tagv_w0_i == s2_physical_addr_i[31:11]);
    assign hit1     = s2_valid1_i & (s2_tagv_w1_i == s2_physical_addr_i[31:11]);
    assign hit_any  = hit0 | hit1;
    assign hit_word = hit1 ? s2_data_way1_i : s2_data_way0_i;
    assign bank     = s2_virtual_addr_i[4:2];
    assign unused_vaddr = ^{s2_virtual_addr_i[31:5], s2_virtual_addr_i[1:0]};

    // s1 keeps presenting a finished request for one more cycle; it must not restart.
    assign accept   = (state_q == IDLE) & ~done_q;
    assign need_bus = (s2_cache_rreq_i & ~hit_any) | s2_uc_rreq_i | s2_cache_wreq_i | s2_uc_wreq_i;
    assign load_hit = accept & s2_cache_rreq_i & hit_any;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s2_cache_wreq_i | s2_uc_wreq_i)      state_d = WRITE;
                    else if (s2_uc_rreq_i)                   state_d = UC_READ;
                    else if (s2_cache_rreq_i & ~hit_any)     state_d = CA_READ;
                end
            end
            CA_READ: if (axi_rend_i) state_d = IDLE;
            UC_READ: if (axi_rend_i) state_d = IDLE;
            WRITE:   if (axi_wend_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q != IDLE) & (state_d == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q     <= '0;
            axi_rreq_o  <= 1'b0;
            axi_raddr_o <= '0;
            axi_rlen_o  <= 1'b0;
            axi_wreq_o  <= 1'b0;
            axi_waddr_o <= '0;
            axi_wdata_o <= '0;
            axi_wstrb_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (state_d == CA_READ) begin
                        axi_rreq_o  <= 1'b1;
                        axi_raddr_o <= {s2_physical_addr_i[31:5], 5'b0};
                        axi_rlen_o  <= 1'b1;
                    end else if (state_d == UC_READ) begin
                        axi_rreq_o  <= 1'b1;
                        axi_raddr_o <= s2_physical_addr_i;
                        axi_rlen_o  <= 1'b0;
                    end else if (state_d == WRITE) begin
                        axi_wreq_o  <= 1'b1;
                        axi_waddr_o <= {s2_physical_addr_i[31:2], 2'b0};
                        axi_wdata_o <= s2_bus_wdata_i;
                        axi_wstrb_o <= s2_bus_wen_i;
                    end
                end
                CA_READ: if (axi_rend_i) begin
                    axi_rreq_o <= 1'b0;
                    rdata_q    <= axi_rline_i[32*bank +: 32];
                end
                UC_READ: if (axi_rend_i) begin
                    axi_rreq_o <= 1'b0;
                    rdata_q    <= axi_rline_i[31:0];
                end
                WRITE: if (axi_wend_i) axi_wreq_o <= 1'b0;
                default: ;
            endcase
        end
    end

    assign align_in    = done_q ? rdata_q : hit_word;
    assign merged_word = merge_bytes(hit_word, s2_bus_wdata_i, s2_bus_wen_i);

    dcache_load_align u_align (
        .word   (align_in),
        .offset (s2_physical_addr_i[1:0]),
        .size   (s2_bus_load_size_i),
        .data   (aligned)
    );

    // Request-driven outputs are forced low while reset is held.
    always_comb begin
        s2_hit_rdata_o = '0;
        if (rst_n) s2_hit_rdata_o[32*bank +: 32] = merged_word;
    end

    assign s2_hit1_o    = rst_n & hit0;
    assign s2_hit2_o    = rst_n & hit1;
    assign s2_s2rreq_o  = rst_n & s2_cache_rreq_i;
    assign s2_s2wreq_o  = rst_n & s2_cache_wreq_i;
    assign s2_status_o  = state_q;
    assign s2_hit_wen_o = rst_n & accept & s2_cache_wreq_i & hit_any;
    assign s2_stall_o   = rst_n & ((state_q != IDLE) | (accept & need_bus));
    assign s2_rdata_o   = (rst_n & (done_q | load_hit)) ? aligned : 32'h0;

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(hit0 && hit1));
    end

endmodule

// File: tb/tb_dcache_s2.sv
// Directed bench for dcache_s2: load data is scoreboarded, all other outputs are
// checked against constants at each step.
module tb_dcache_s2;
    import dcache_s2_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [31:0]       vaddr, paddr;
    logic [TAG_W-1:0]  tag0, tag1;
    logic              valid0, valid1;
    logic [31:0]       data0, data1;
    logic              cache_rreq, cache_wreq, uc_rreq, uc_wreq;
    logic [3:0]        wen;
    logic [31:0]       wdata;
    logic [1:0]        load_size;
    logic              s2_hit1_o, s2_hit2_o, s2_s2rreq_o, s2_s2wreq_o;
    logic [1:0]        s2_status_o;
    logic              s2_hit_wen_o;
    logic [LINE_W-1:0] s2_hit_rdata_o;
    logic              s2_stall_o;
    logic [31:0]       s2_rdata_o;
    logic              axi_rreq_o, axi_rlen_o, axi_wreq_o;
    logic [31:0]       axi_raddr_o, axi_waddr_o, axi_wdata_o;
    logic [3:0]        axi_wstrb_o;
    logic              rend, wend;
    logic [LINE_W-1:0] rline;

    int checks   = 0;
    int failures = 0;
    logic [31:0] expected_rdata[$];
    logic [LINE_W-1:0] exp_line;

    localparam logic [TAG_W-1:0] TAG_A = 21'h3F800;

    dcache_s2 dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s2_virtual_addr_i  (vaddr),
        .s2_physical_addr_i (paddr),
        .s2_tagv_w0_i       (tag0),
        .s2_tagv_w1_i       (tag1),
        .s2_valid0_i        (valid0),
        .s2_valid1_i        (valid1),
        .s2_data_way0_i     (data0),
        .s2_data_way1_i     (data1),
        .s2_cache_rreq_i    (cache_rreq),
        .s2_cache_wreq_i    (cache_wreq),
        .s2_uc_rreq_i       (uc_rreq),
        .s2_uc_wreq_i       (uc_wreq),
        .s2_bus_wen_i       (wen),
        .s2_bus_wdata_i     (wdata),
        .s2_bus_load_size_i (load_size),
        .s2_hit1_o          (s2_hit1_o),
        .s2_hit2_o          (s2_hit2_o),
        .s2_s2rreq_o        (s2_s2rreq_o),
        .s2_s2wreq_o        (s2_s2wreq_o),
        .s2_status_o        (s2_status_o),
        .s2_hit_wen_o       (s2_hit_wen_o),
        .s2_hit_rdata_o     (s2_hit_rdata_o),
        .s2_stall_o         (s2_stall_o),
        .s2_rdata_o         (s2_rdata_o),
        .axi_rreq_o         (axi_rreq_o),
        .axi_raddr_o        (axi_raddr_o),
        .axi_rlen_o         (axi_rlen_o),
        .axi_rend_i         (rend),
        .axi_rline_i        (rline),
        .axi_wreq_o         (axi_wreq_o),
        .axi_waddr_o        (axi_waddr_o),
        .axi_wdata_o        (axi_wdata_o),
        .axi_wstrb_o        (axi_wstrb_o),
        .axi_wend_i         (wend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setWays(input logic v0, input logic [TAG_W-1:0] t0, input logic [31:0] d0,
                           input logic v1, input logic [TAG_W-1:0] t1, input logic [31:0] d1);
        valid0 = v0; tag0 = t0; data0 = d0;
        valid1 = v1; tag1 = t1; data1 = d1;
    endtask

    // req bits are {uc_wreq, uc_rreq, cache_wreq, cache_rreq}
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] req, input logic [1:0] size,
                                 input logic [3:0] strb, input logic [31:0] store_data);
        vaddr = addr;
        paddr = addr;
        {uc_wreq, uc_rreq, cache_wreq, cache_rreq} = req;
        load_size = size;
        wen = strb;
        wdata = store_data;
    endtask

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed, input logic [LINE_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRdata(input string tag);
        logic [31:0] exp_val;
        if (expected_rdata.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s scoreboard empty observed=%0h", tag, s2_rdata_o);
        end else begin
            exp_val = expected_rdata.pop_front();
            checkOutput(tag, s2_rdata_o, exp_val);
        end
    endtask

    task automatic waitAxiRreq(input string tag);
        int n = 0;
        while (axi_rreq_o !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, axi_rreq_o, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        rend = 1'b0;
        wend = 1'b0;
        rline = '0;
        setWays(1'b0, '0, '0, 1'b0, '0, '0);
        applyStimulus(32'h0, 4'b0000, SIZE_WORD, 4'b0000, 32'h0);

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_status", s2_status_o, 2'd0);
        checkOutput("reset_stall", s2_stall_o, 1'b0);
        checkOutput("reset_rreq", axi_rreq_o, 1'b0);
        checkOutput("reset_wreq", axi_wreq_o, 1'b0);
        checkOutput("reset_rdata", s2_rdata_o, 32'h0);
        checkOutput("reset_hit_wen", s2_hit_wen_o, 1'b0);
        nextCycle();
        rst_n = 1'b1;

        // Cached load hits in way1: byte, word and high half
        nextCycle();
        setWays(1'b1, 21'h3F801, 32'h0, 1'b1, TAG_A, 32'hAABBCCDD);
        applyStimulus(32'h1fc00024, 4'b0001, SIZE_BYTE, 4'b0000, 32'h0);
        expected_rdata.push_back(32'h000000DD);
        @(negedge clk);
        checkOutput("hit_way0", s2_hit1_o, 1'b0);
        checkOutput("hit_way1", s2_hit2_o, 1'b1);
        checkOutput("hit_stall", s2_stall_o, 1'b0);
        checkOutput("hit_s2rreq", s2_s2rreq_o, 1'b1);
        checkRdata("hit_byte_rdata");
        nextCycle();
        applyStimulus(32'h1fc00024, 4'b0001, SIZE_WORD, 4'b0000, 32'h0);
        expected_rdata.push_back(32'hAABBCCDD);
        @(negedge clk);
        checkRdata("hit_word_rdata");
        checkOutput("hit_no_axi", axi_rreq_o, 1'b0);
        nextCycle();
        applyStimulus(32'h1fc00026, 4'b0001, SIZE_HALF, 4'b0000, 32'h0);
        expected_rdata.push_back(32'h0000AABB);
        @(negedge clk);
        checkRdata("hit_half_rdata");
        checkOutput("hit_status", s2_status_o, 2'd0);

        // Cached load miss, bank 2 refill
        nextCycle();
        setWays(1'b1, 21'h3F801, 32'h0, 1'b1, 21'h00001, 32'h0);
        applyStimulus(32'h1fc00028, 4'b0001, SIZE_WORD, 4'b0000, 32'h0);
        expected_rdata.push_back(32'h22222222);
        @(negedge clk);
        checkOutput("miss_stall_detect", s2_stall_o, 1'b1);
        checkOutput("miss_way1", s2_hit2_o, 1'b0);
        checkOutput("miss_rreq_not_yet", axi_rreq_o, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("miss_rreq", axi_rreq_o, 1'b1);
        checkOutput("miss_raddr", axi_raddr_o, 32'h1fc00020);
        checkOutput("miss_rlen", axi_rlen_o, 1'b1);
        checkOutput("miss_status", s2_status_o, 2'd1);
        nextCycle();
        for (int k = 0; k < 8; k++) rline[32*k +: 32] = 32'h11111111 * k;
        rend = 1'b1;
        @(negedge clk);
        checkOutput("miss_stall_on_rend", s2_stall_o, 1'b1);
        nextCycle();
        rend = 1'b0;
        @(negedge clk);
        checkOutput("miss_done_status", s2_status_o, 2'd0);
        checkOutput("miss_done_stall", s2_stall_o, 1'b0);
        checkOutput("miss_done_rreq", axi_rreq_o, 1'b0);
        checkOutput("miss_held_s2rreq", s2_s2rreq_o, 1'b1);
        checkRdata("miss_rdata");
        nextCycle();
        applyStimulus(32'h0, 4'b0000, SIZE_WORD, 4'b0000, 32'h0);

        // Cached store hit in way1, bank 1
        nextCycle();
        setWays(1'b1, 21'h3F801, 32'h0, 1'b1, TAG_A, 32'hAABBCCDD);
        applyStimulus(32'h1fc00024, 4'b0010, SIZE_WORD, 4'b0011, 32'h12345678);
        exp_line = '0;
        exp_line[63:32] = 32'hAABB5678;
        @(negedge clk);
        checkOutput("store_hit_wen", s2_hit_wen_o, 1'b1);
        checkOutput("store_hit_rdata", s2_hit_rdata_o, exp_line);
        checkOutput("store_stall", s2_stall_o, 1'b1);
        checkOutput("store_s2wreq", s2_s2wreq_o, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("store_hit_wen_pulse", s2_hit_wen_o, 1'b0);
        checkOutput("store_wreq", axi_wreq_o, 1'b1);
        checkOutput("store_waddr", axi_waddr_o, 32'h1fc00024);
        checkOutput("store_wdata", axi_wdata_o, 32'h12345678);
        checkOutput("store_wstrb", axi_wstrb_o, 4'b0011);
        checkOutput("store_status", s2_status_o, 2'd3);
        nextCycle();
        wend = 1'b1;
        @(negedge clk);
        checkOutput("store_stall_on_wend", s2_stall_o, 1'b1);
        nextCycle();
        wend = 1'b0;
        @(negedge clk);
        checkOutput("store_done_stall", s2_stall_o, 1'b0);
        checkOutput("store_done_wreq", axi_wreq_o, 1'b0);
        checkOutput("store_done_hit_wen", s2_hit_wen_o, 1'b0);
        checkOutput("store_done_status", s2_status_o, 2'd0);

        // Uncached halfword load, issued straight after the store completes
        nextCycle();
        setWays(1'b0, '0, 32'h0, 1'b0, '0, 32'h0);
        applyStimulus(32'h1faff002, 4'b0100, SIZE_HALF, 4'b0000, 32'h0);
        expected_rdata.push_back(32'h0000BEEF);
        @(negedge clk);
        checkOutput("uc_stall_detect", s2_stall_o, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("uc_rreq", axi_rreq_o, 1'b1);
        checkOutput("uc_raddr", axi_raddr_o, 32'h1faff002);
        checkOutput("uc_rlen", axi_rlen_o, 1'b0);
        checkOutput("uc_status", s2_status_o, 2'd2);
        nextCycle();
        for (int k = 1; k < 8; k++) rline[32*k +: 32] = $urandom;
        rline[31:0] = 32'hBEEF0000;
        rend = 1'b1;
        nextCycle();
        rend = 1'b0;
        @(negedge clk);
        checkOutput("uc_done_stall", s2_stall_o, 1'b0);
        checkRdata("uc_rdata");
        nextCycle();
        applyStimulus(32'h0, 4'b0000, SIZE_WORD, 4'b0000, 32'h0);

        // Stray write-end while idle
        nextCycle();
        wend = 1'b1;
        @(negedge clk);
        checkOutput("stray_wend_status", s2_status_o, 2'd0);
        checkOutput("stray_wend_wreq", axi_wreq_o, 1'b0);
        nextCycle();
        wend = 1'b0;

        // Reset while a refill is outstanding
        nextCycle();
        setWays(1'b1, 21'h3F801, 32'h0, 1'b1, 21'h00001, 32'h0);
        applyStimulus(32'h1fc00028, 4'b0001, SIZE_WORD, 4'b0000, 32'h0);
        waitAxiRreq("refill_started");
        nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_rreq", axi_rreq_o, 1'b0);
        checkOutput("rst_mid_stall", s2_stall_o, 1'b0);
        checkOutput("rst_mid_status", s2_status_o, 2'd0);
        applyStimulus(32'h0, 4'b0000, SIZE_WORD, 4'b0000, 32'h0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        rend = 1'b1;
        @(negedge clk);
        checkOutput("stray_rend_status", s2_status_o, 2'd0);
        checkOutput("stray_rend_rreq", axi_rreq_o, 1'b0);
        nextCycle();
        rend = 1'b0;
        @(negedge clk);
        checkOutput("stray_rend_stall", s2_stall_o, 1'b0);
        checkOutput("stray_rend_rdata", s2_rdata_o, 32'h0);

        checkOutput("scoreboard_drained", expected_rdata.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
